serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 85 ++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor step per cycle, LSB first.
// state | meaning: IDLE wait for start | SHIFT one bit per cycle | DONE result valid, done pulse
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] sa, sb, res;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             d, bout;

    assign d    = sa[0] ^ sb[0] ^ bin;
    assign bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            bin   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                sa  <= a;
                sb  <= b;
                bin <= 1'b0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                // each difference bit enters at the MSB so bit 0 lands at bit 0 after WIDTH steps
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                res <= {d, res[WIDTH-1:1]};
                bin <= bout;
                cnt <= cnt + CW'(1);
            end
        end
    end

    // the borrow flop is untouched after SHIFT, so it doubles as the held borrow result
    assign diff   = res;
    assign borrow = bin;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit vector table, corner sequences, 4-bit exhaustive sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, busy8, done8, borrow8;
    logic [7:0] a8, b8, diff8;
    logic       start4, busy4, done4, borrow4;
    logic [3:0] a4, b4, diff4;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] ed, input logic eb);
        int k;
        int nb;
        a8 = ta; b8 = tb; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~ta; b8 = ~tb;
        k = 1; nb = 0;
        while (!done8 && k < 40) begin
            if (busy8) nb++;
            @(negedge clk);
            k++;
        end
        chk("latency8", k, 9);
        chk("busy_cycles8", nb, 8);
        chk("diff8", diff8, ed);
        chk("borrow8", borrow8, eb);
        chk("busy_in_done8", busy8, 0);
        @(negedge clk);
        chk("done_pulse8", done8, 0);
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb);
        int k;
        logic [3:0] ed;
        ed = 4'((int'(ta) - int'(tb)) & 15);
        a4 = ta; b4 = tb; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        k = 1;
        while (!done4 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("latency4", k, 5);
        chk("diff4", diff4, ed);
        chk("borrow4", borrow4, (ta < tb) ? 1 : 0);
        @(negedge clk);
    endtask

    initial begin
        int k, nd, nb, d1, d2;

        tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        tbl[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
        tbl[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        tbl[6] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        tbl[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
        tbl[8] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_diff8", diff8, 0);
        chk("rst_borrow8", borrow8, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_diff4", diff4, 0);
        chk("rst_borrow4", borrow4, 0);

        // start presented on the very first edge after reset release
        rst = 1'b0;
        for (int i = 0; i < 9; i++) op8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo);

        // start and operand changes during SHIFT and DONE are ignored
        a8 = 8'h0A; b8 = 8'h04; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF;
        k = 1;
        while (!done8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ign_latency", k, 9);
        chk("ign_diff", diff8, 8'h06);
        chk("ign_borrow", borrow8, 0);
        a8 = 8'h33; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        chk("ign_done_drop", done8, 0);
        chk("ign_busy_idle", busy8, 0);
        nd = 0; nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) nd++;
            if (busy8) nb++;
        end
        chk("ign_no_second_done", nd, 0);
        chk("ign_no_second_busy", nb, 0);
        chk("ign_diff_held", diff8, 8'h06);
        chk("ign_borrow_held", borrow8, 0);

        // reset in the fourth SHIFT cycle aborts the operation
        a8 = 8'h0A; b8 = 8'h04; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_diff", diff8, 0);
        chk("abort_borrow", borrow8, 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("abort_no_done", nd, 0);
        op8(8'h10, 8'h01, 8'h0F, 1'b0);

        // reset wins over start in the same cycle
        rst = 1'b1; start8 = 1'b1; a8 = 8'h55; b8 = 8'h11;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        chk("rst_prio_busy", busy8, 0);
        @(negedge clk);
        chk("rst_prio_busy_next", busy8, 0);

        // start held high: one result every WIDTH+2 cycles
        a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
        k = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && k < 60) begin
            @(negedge clk);
            k++;
            if (done8) begin
                if (d1 < 0) d1 = k;
                else d2 = k;
            end
        end
        start8 = 1'b0;
        chk("hold_period", d2 - d1, 10);
        chk("hold_diff", diff8, 8'h1F);
        repeat (12) @(negedge clk);

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                op4(4'(ia), 4'(ib));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
